// File: rtl/vr_fifo_wm_if.sv
// Valid/ready write and read channels of the watermark FIFO.
// The master side is the producer/consumer; the slave side is the FIFO itself.
interface vr_fifo_wm_if #(
  parameter int D_WIDTH = 64
);
  logic               wr_vld;
  logic               wr_rdy;
  logic [D_WIDTH-1:0] wr_data;
  logic               rd_vld;
  logic               rd_rdy;
  logic [D_WIDTH-1:0] rd_data;

  modport master (
    output wr_vld,
    output wr_data,
    output rd_rdy,
    input  wr_rdy,
    input  rd_vld,
    input  rd_data
  );

  modport slave (
    input  wr_vld,
    input  wr_data,
    input  rd_rdy,
    output wr_rdy,
    output rd_vld,
    output rd_data
  );
endinterface

// File: rtl/vr_fifo_wm.sv
// Single-clock valid/ready FIFO with almost-full/almost-empty watermarks.
// It can back-pressure the writer, or it can drop words and count overflows.
module vr_fifo_wm #(
  parameter int D_WIDTH   = 64,
  parameter int D_DEPTH   = 8,
  parameter int AF_LEVEL  = D_DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int DROP_MODE = 0,
  parameter int DC_WIDTH  = 8,
  localparam int CW = ($clog2(D_DEPTH + 1) > 1) ? $clog2(D_DEPTH + 1) : 1,
  localparam int PW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  vr_fifo_wm_if.slave         bus_if,
  output logic [CW-1:0]       cnt_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic                ovf_o,
  output logic [DC_WIDTH-1:0] drop_cnt_o
);

  localparam bit DROP_EN = (DROP_MODE != 0);

  logic [D_WIDTH-1:0]  mem_q [D_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [DC_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic full_s;
  logic rd_vld_s;
  logic wr_rdy_s;
  logic rd_fire_s;
  logic wr_fire_s;
  logic drop_s;
  logic store_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(D_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Handshake decode: a drop is an accepted write that finds no free slot.
  always_comb begin
    full_s    = (cnt_q == CW'(D_DEPTH));
    rd_vld_s  = (cnt_q != {CW{1'b0}}) && !flush_i;
    rd_fire_s = rd_vld_s && bus_if.rd_rdy;
    if (DROP_EN) begin
      wr_rdy_s = !flush_i;
    end else begin
      wr_rdy_s = (!full_s || rd_fire_s) && !flush_i;
    end
    wr_fire_s = bus_if.wr_vld && wr_rdy_s;
    drop_s    = DROP_EN && wr_fire_s && full_s && !rd_fire_s;
    store_s   = wr_fire_s && !drop_s;
  end

  // Next-state computation for pointers, occupancy and overflow status.
  always_comb begin
    wr_ptr_d = store_s   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_fire_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({store_s, rd_fire_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q || drop_s;
    if (drop_s && (drop_cnt_q != {DC_WIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DC_WIDTH'(1'b1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control state; reset and flush clear identically, reset simply wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      ovf_q      <= 1'b0;
      drop_cnt_q <= {DC_WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array is intentionally not reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (store_s) begin
      mem_q[wr_ptr_q] <= bus_if.wr_data;
    end
  end

  assign bus_if.wr_rdy  = wr_rdy_s;
  assign bus_if.rd_vld  = rd_vld_s;
  assign bus_if.rd_data = mem_q[rd_ptr_q];
  assign cnt_o          = cnt_q;
  assign almost_full_o  = (cnt_q >= CW'(AF_LEVEL));
  assign almost_empty_o = (cnt_q <= CW'(AE_LEVEL));
  assign ovf_o          = ovf_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_vr_fifo_wm.sv
// Self-checking bench: three FIFO instances (back-pressure depth 5, drop depth 5,
// back-pressure depth 1) run against a queue-based reference model.
module tb_vr_fifo_wm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        wv [3];
  logic        rr [3];
  logic [15:0] wd [3];

  int checks = 0;
  int errors = 0;

  vr_fifo_wm_if #(.D_WIDTH(16)) if0 ();
  vr_fifo_wm_if #(.D_WIDTH(16)) if1 ();
  vr_fifo_wm_if #(.D_WIDTH(16)) if2 ();

  assign if0.wr_vld = wv[0];  assign if0.wr_data = wd[0];  assign if0.rd_rdy = rr[0];
  assign if1.wr_vld = wv[1];  assign if1.wr_data = wd[1];  assign if1.rd_rdy = rr[1];
  assign if2.wr_vld = wv[2];  assign if2.wr_data = wd[2];  assign if2.rd_rdy = rr[2];

  logic [2:0] cnt0, cnt1;
  logic [0:0] cnt2;
  logic       af0, af1, af2, ae0, ae1, ae2, ovf0, ovf1, ovf2;
  logic [3:0] dc0, dc1, dc2;

  vr_fifo_wm #(.D_WIDTH(16), .D_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .DROP_MODE(0), .DC_WIDTH(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus_if(if0), .cnt_o(cnt0),
    .almost_full_o(af0), .almost_empty_o(ae0), .ovf_o(ovf0), .drop_cnt_o(dc0));
  vr_fifo_wm #(.D_WIDTH(16), .D_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .DROP_MODE(1), .DC_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus_if(if1), .cnt_o(cnt1),
    .almost_full_o(af1), .almost_empty_o(ae1), .ovf_o(ovf1), .drop_cnt_o(dc1));
  vr_fifo_wm #(.D_WIDTH(16), .D_DEPTH(1), .AF_LEVEL(1), .AE_LEVEL(0), .DROP_MODE(0), .DC_WIDTH(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus_if(if2), .cnt_o(cnt2),
    .almost_full_o(af2), .almost_empty_o(ae2), .ovf_o(ovf2), .drop_cnt_o(dc2));

  logic [2:0]  a_cnt [3];
  logic        a_wrdy [3], a_rvld [3], a_af [3], a_ae [3], a_ovf [3];
  logic [3:0]  a_dc [3];
  logic [15:0] a_rd [3];

  assign a_cnt[0] = cnt0;  assign a_cnt[1] = cnt1;  assign a_cnt[2] = {2'b00, cnt2};
  assign a_wrdy[0] = if0.wr_rdy;  assign a_wrdy[1] = if1.wr_rdy;  assign a_wrdy[2] = if2.wr_rdy;
  assign a_rvld[0] = if0.rd_vld;  assign a_rvld[1] = if1.rd_vld;  assign a_rvld[2] = if2.rd_vld;
  assign a_rd[0] = if0.rd_data;   assign a_rd[1] = if1.rd_data;   assign a_rd[2] = if2.rd_data;
  assign a_af[0] = af0;  assign a_af[1] = af1;  assign a_af[2] = af2;
  assign a_ae[0] = ae0;  assign a_ae[1] = ae1;  assign a_ae[2] = ae2;
  assign a_ovf[0] = ovf0;  assign a_ovf[1] = ovf1;  assign a_ovf[2] = ovf2;
  assign a_dc[0] = dc0;  assign a_dc[1] = dc1;  assign a_dc[2] = dc2;

  // Reference model: one scoreboard queue per instance plus sticky status.
  logic [15:0] mq [3][$];
  bit          ovf_m [3];
  int          dc_m [3];

  function automatic int dep(input int k);  return (k == 2) ? 1 : 5;  endfunction
  function automatic bit dm(input int k);   return (k == 1);          endfunction
  function automatic int afl(input int k);  return (k == 2) ? 1 : 4;  endfunction
  function automatic int ael(input int k);  return (k == 2) ? 0 : 1;  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs against the model, then advance the model one edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      int c;
      bit full, rv, rd, wrdy, wr, drop;
      c    = mq[k].size();
      full = (c == dep(k));
      rv   = (c != 0) && !flush;
      rd   = rv && rr[k];
      wrdy = dm(k) ? !flush : ((!full || rd) && !flush);
      wr   = wv[k] && wrdy;
      drop = dm(k) && wr && full && !rd;
      chk($sformatf("cnt%0d", k), a_cnt[k], c);
      chk($sformatf("rd_vld%0d", k), a_rvld[k], rv);
      chk($sformatf("wr_rdy%0d", k), a_wrdy[k], wrdy);
      chk($sformatf("af%0d", k), a_af[k], (c >= afl(k)));
      chk($sformatf("ae%0d", k), a_ae[k], (c <= ael(k)));
      chk($sformatf("ovf%0d", k), a_ovf[k], ovf_m[k]);
      chk($sformatf("drop_cnt%0d", k), a_dc[k], dc_m[k]);
      if (rv) chk($sformatf("rd_data%0d", k), a_rd[k], mq[k][0]);
      if (rst || flush) begin
        mq[k].delete();
        ovf_m[k] = 1'b0;
        dc_m[k]  = 0;
      end else begin
        if (rd) void'(mq[k].pop_front());
        if (wr && !drop) mq[k].push_back(wd[k]);
        if (drop) begin
          ovf_m[k] = 1'b1;
          if (dc_m[k] < 15) dc_m[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input bit w, input logic [15:0] d, input bit r);
    for (int k = 0; k < 3; k++) begin
      wv[k] = w;
      wd[k] = d;
      rr[k] = r;
    end
  endtask

  typedef struct {
    bit          wv;
    logic [15:0] wd;
    bit          rr;
    int          ecnt;
    bit          eaf;
    bit          ewrdy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 1'b0, 0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h0002, 1'b0, 1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h0003, 1'b0, 2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h0004, 1'b0, 3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'h0005, 1'b0, 4, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 16'h0006, 1'b0, 5, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      ovf_m[k] = 1'b0;
      dc_m[k]  = 0;
    end
    flush = 1'b0;
    drive_all(1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Fill sequence with explicit expectations for the back-pressure instance.
    for (int i = 0; i < 6; i++) begin
      drive_all(tbl[i].wv, tbl[i].wd, tbl[i].rr);
      #1;
      chk("tbl_cnt", a_cnt[0], tbl[i].ecnt);
      chk("tbl_af", a_af[0], tbl[i].eaf);
      chk("tbl_wr_rdy", a_wrdy[0], tbl[i].ewrdy);
      tick();
    end

    // Full with simultaneous write and read: occupancy holds, pointers wrap.
    for (int i = 0; i < 12; i++) begin
      drive_all(1'b1, 16'h0100 + 16'(i), 1'b1);
      tick();
    end
    drive_all(1'b0, 16'h0000, 1'b0);
    #1;
    chk("full_hold_cnt0", a_cnt[0], 5);
    chk("full_hold_cnt2", a_cnt[2], 1);

    // Sustained writes while full: drop instance saturates its counter.
    for (int i = 0; i < 20; i++) begin
      drive_all(1'b1, 16'h0200 + 16'(i), 1'b0);
      tick();
    end
    drive_all(1'b0, 16'h0000, 1'b0);
    #1;
    chk("drop_sat", a_dc[1], 15);
    chk("drop_ovf", a_ovf[1], 1);
    chk("drop_cnt_hold", a_cnt[1], 5);

    drive_all(1'b0, 16'h0000, 1'b1);
    tick();
    tick();

    // Flush with a concurrent write and read.
    flush = 1'b1;
    drive_all(1'b1, 16'hDEAD, 1'b1);
    tick();
    flush = 1'b0;
    drive_all(1'b0, 16'h0000, 1'b0);
    #1;
    chk("flush_cnt", a_cnt[0], 0);
    chk("flush_rd_vld", a_rvld[0], 0);
    chk("flush_ovf", a_ovf[1], 0);
    chk("flush_drop_cnt", a_dc[1], 0);
    tick();

    // One-cycle write-to-read latency from empty.
    drive_all(1'b1, 16'hABCD, 1'b0);
    tick();
    drive_all(1'b0, 16'h0000, 1'b0);
    #1;
    chk("lat_rd_vld", a_rvld[0], 1);
    chk("lat_rd_data", a_rd[0], 16'hABCD);
    chk("lat_ae", a_ae[0], 1);
    drive_all(1'b0, 16'h0000, 1'b1);
    tick();

    // Reset in the middle of operation discards stored words.
    for (int i = 0; i < 4; i++) begin
      drive_all(1'b1, 16'h0300 + 16'(i), 1'b0);
      tick();
    end
    drive_all(1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cnt", a_cnt[0], 0);
    chk("rst_rd_vld", a_rvld[0], 0);
    chk("rst_wr_rdy", a_wrdy[0], 1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        wv[k] = 1'($urandom_range(0, 1));
        rr[k] = 1'($urandom_range(0, 1));
        wd[k] = 16'($urandom);
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    drive_all(1'b0, 16'h0000, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
